// File: rtl/counter_pkg.sv
// Shared constants and helpers for the up/down counter family.
package counter_pkg;

  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Wide enough for any counter width used in the design; callers truncate.
  localparam int CLAMP_W = 32;

  function automatic logic [CLAMP_W-1:0] clamp(input logic [CLAMP_W-1:0] val,
                                               input logic [CLAMP_W-1:0] lim);
    return (val > lim) ? lim : val;
  endfunction

endpackage

// File: rtl/mod_updown_next.sv
// Combinational next-count logic: one up/down step with wrap or saturate at 0..limit.
module mod_updown_next
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4,
  parameter int SAT_MODE = CNT_WRAP
) (
  input  logic [WIDTH-1:0]  count,
  input  logic [WIDTH-1:0]  limit,
  input  logic [STEP_W-1:0] step,
  input  logic              up_down,
  output logic [WIDTH-1:0]  count_nxt,
  output logic              ovf,
  output logic              unf
);

  localparam bit IS_SAT = (SAT_MODE == CNT_SAT);

  logic        [WIDTH:0] step_ext;
  logic        [WIDTH:0] limit_ext;
  logic        [WIDTH:0] sum;
  logic signed [WIDTH:0] diff;
  logic                  out_of_range;
  logic                  above_limit;
  logic                  borrow;

  assign step_ext  = {{(WIDTH + 1 - STEP_W){1'b0}}, step};
  assign limit_ext = {1'b0, limit};

  // One extra bit keeps the carry of count+step and the sign of count-step.
  assign sum  = {1'b0, count} + step_ext;
  assign diff = $signed({1'b0, count}) - $signed(step_ext);

  assign out_of_range = (count > limit);
  assign above_limit  = (sum > limit_ext);
  assign borrow       = diff[WIDTH];

  function automatic logic [WIDTH-1:0] up_target(input logic [WIDTH-1:0] lim);
    return IS_SAT ? lim : '0;
  endfunction

  function automatic logic [WIDTH-1:0] down_target(input logic [WIDTH-1:0] lim);
    return IS_SAT ? '0 : lim;
  endfunction

  always_comb begin
    count_nxt = count;
    ovf       = 1'b0;
    unf       = 1'b0;
    if (out_of_range) begin
      // LIMIT was lowered under the count: snap back silently.
      count_nxt = limit;
    end else if (up_down) begin
      if (!above_limit) begin
        count_nxt = sum[WIDTH-1:0];
      end else begin
        count_nxt = up_target(limit);
        ovf       = IS_SAT ? (count != limit) : 1'b1;
      end
    end else begin
      if (!borrow) begin
        count_nxt = diff[WIDTH-1:0];
      end else begin
        count_nxt = down_target(limit);
        unf       = IS_SAT ? (count != '0) : 1'b1;
      end
    end
  end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with limit, load, step and wrap/saturate end mode.
module mod_updown_counter
  import counter_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int STEP_W   = 4,
  parameter int SAT_MODE = CNT_WRAP
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              EN,
  input  logic              UP_DOWN,
  input  logic              LOAD,
  input  logic [WIDTH-1:0]  LOAD_VAL,
  input  logic [WIDTH-1:0]  LIMIT,
  input  logic [STEP_W-1:0] STEP,
  output logic [WIDTH-1:0]  COUNT,
  output logic              TC,
  output logic              OVF,
  output logic              UNF
);

  logic [WIDTH-1:0] count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  logic [WIDTH-1:0] step_count;
  logic             step_ovf;
  logic             step_unf;
  logic [WIDTH-1:0] load_count;

  mod_updown_next #(
    .WIDTH    (WIDTH),
    .STEP_W   (STEP_W),
    .SAT_MODE (SAT_MODE)
  ) u_next (
    .count     (count_q),
    .limit     (LIMIT),
    .step      (STEP),
    .up_down   (UP_DOWN),
    .count_nxt (step_count),
    .ovf       (step_ovf),
    .unf       (step_unf)
  );

  assign load_count = WIDTH'(clamp(CLAMP_W'(LOAD_VAL), CLAMP_W'(LIMIT)));

  // LOAD outranks EN; pulses default low so they last exactly one cycle.
  always_comb begin
    count_d = count_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    if (LOAD) begin
      count_d = load_count;
    end else if (EN) begin
      count_d = step_count;
      ovf_d   = step_ovf;
      unf_d   = step_unf;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      count_q <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign COUNT = count_q;
  assign OVF   = ovf_q;
  assign UNF   = unf_q;
  assign TC    = UP_DOWN ? (count_q == LIMIT) : (count_q == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed vector bench for mod_updown_counter: wrap/sat at WIDTH=8 and wrap at WIDTH=4.
module tb_mod_updown_counter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0, ud = 1'b1, ld = 1'b0;
  logic [7:0] lval = '0, lim = 8'd9;
  logic [3:0] step = 4'd1;

  logic [7:0] w_cnt, s_cnt;
  logic       w_tc, w_ovf, w_unf, s_tc, s_ovf, s_unf;

  logic       f_en = 1'b0, f_ud = 1'b1, f_ld = 1'b0;
  logic [3:0] f_lval = '0, f_lim = 4'd15, f_step = 4'd1;
  logic [3:0] f_cnt;
  logic       f_tc, f_ovf, f_unf;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mod_updown_counter #(.WIDTH(8), .STEP_W(4), .SAT_MODE(0)) u_wrap (
    .CLK(clk), .RESET(rst), .EN(en), .UP_DOWN(ud), .LOAD(ld), .LOAD_VAL(lval),
    .LIMIT(lim), .STEP(step), .COUNT(w_cnt), .TC(w_tc), .OVF(w_ovf), .UNF(w_unf)
  );

  mod_updown_counter #(.WIDTH(8), .STEP_W(4), .SAT_MODE(1)) u_sat (
    .CLK(clk), .RESET(rst), .EN(en), .UP_DOWN(ud), .LOAD(ld), .LOAD_VAL(lval),
    .LIMIT(lim), .STEP(step), .COUNT(s_cnt), .TC(s_tc), .OVF(s_ovf), .UNF(s_unf)
  );

  mod_updown_counter #(.WIDTH(4), .STEP_W(4), .SAT_MODE(0)) u_w4 (
    .CLK(clk), .RESET(rst), .EN(f_en), .UP_DOWN(f_ud), .LOAD(f_ld), .LOAD_VAL(f_lval),
    .LIMIT(f_lim), .STEP(f_step), .COUNT(f_cnt), .TC(f_tc), .OVF(f_ovf), .UNF(f_unf)
  );

  typedef struct {
    logic       rst, en, ud, ld;
    logic [7:0] lval, lim;
    logic [3:0] step;
    logic [7:0] ecnt;
    logic       eovf, eunf, etc;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic e, input logic u, input logic l,
                     input logic [7:0] lv, input logic [7:0] lm, input logic [3:0] st,
                     input logic [7:0] c, input logic o, input logic un, input logic t);
    vec_t v;
    v.rst = r; v.en = e; v.ud = u; v.ld = l; v.lval = lv; v.lim = lm; v.step = st;
    v.ecnt = c; v.eovf = o; v.eunf = un; v.etc = t;
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic e, input logic u, input logic l,
                       input logic [7:0] lv, input logic [7:0] lm, input logic [3:0] st);
    rst = r; en = e; ud = u; ld = l; lval = lv; lim = lm; step = st;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sat(input string tag, input int c, input int o, input int u, input int t);
    chk({tag, " count"}, int'(s_cnt), c);
    chk({tag, " ovf"},   int'(s_ovf), o);
    chk({tag, " unf"},   int'(s_unf), u);
    chk({tag, " tc"},    int'(s_tc),  t);
  endtask

  initial begin
    // Reset held two cycles, then count up 0..9 and wrap.
    add(1, 0, 1, 0, 0, 9, 1, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0, 9, 1, 0, 0, 0, 0);
    for (int i = 1; i <= 9; i++) add(0, 1, 1, 0, 0, 9, 1, 8'(i), 0, 0, (i == 9));
    add(0, 1, 1, 0, 0, 9, 1, 0, 1, 0, 0);
    add(0, 1, 1, 0, 0, 9, 1, 1, 0, 0, 0);
    // Down, wrap from 0.
    add(0, 0, 0, 1, 0, 9, 1, 0, 0, 0, 1);
    add(0, 1, 0, 0, 0, 9, 1, 9, 0, 1, 0);
    add(0, 1, 0, 0, 0, 9, 1, 8, 0, 0, 0);
    add(0, 1, 0, 0, 0, 9, 1, 7, 0, 0, 0);
    // Load beats enable and clamps; lowered limit snaps count down silently.
    add(0, 1, 1, 1, 50, 20, 1, 20, 0, 0, 1);
    add(0, 1, 1, 0, 0, 10, 1, 10, 0, 0, 1);
    add(0, 1, 0, 0, 0, 4, 1, 4, 0, 0, 0);
    // Hold with EN=0 while direction toggles; TC follows UP_DOWN.
    add(0, 0, 1, 1, 9, 9, 3, 9, 0, 0, 1);
    add(0, 0, 0, 0, 0, 9, 3, 9, 0, 0, 0);
    add(0, 0, 1, 0, 0, 9, 3, 9, 0, 0, 1);
    add(0, 0, 0, 0, 0, 9, 3, 9, 0, 0, 0);
    add(0, 0, 1, 0, 0, 9, 3, 9, 0, 0, 1);
    add(0, 0, 0, 0, 0, 9, 3, 9, 0, 0, 0);
    add(0, 1, 1, 0, 0, 9, 0, 9, 0, 0, 1);
    add(0, 1, 0, 0, 0, 9, 0, 9, 0, 0, 0);
    // Wrap drops residue for multi-unit steps.
    add(0, 0, 1, 1, 8, 9, 3, 8, 0, 0, 0);
    add(0, 1, 1, 0, 0, 9, 3, 0, 1, 0, 0);
    add(0, 0, 0, 1, 1, 9, 3, 1, 0, 0, 0);
    add(0, 1, 0, 0, 0, 9, 3, 9, 0, 1, 0);
    // LIMIT=0: every nonzero step pulses.
    add(0, 0, 1, 1, 5, 0, 1, 0, 0, 0, 1);
    add(0, 1, 1, 0, 0, 0, 1, 0, 1, 0, 1);
    add(0, 1, 0, 0, 0, 0, 1, 0, 0, 1, 1);
    add(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1);
    // Reset wins over LOAD and EN, including on a would-be overflow edge.
    add(0, 0, 1, 1, 5, 9, 1, 5, 0, 0, 0);
    add(1, 1, 1, 1, 7, 9, 1, 0, 0, 0, 0);
    add(0, 0, 1, 1, 9, 9, 1, 9, 0, 0, 1);
    add(1, 1, 1, 0, 0, 9, 1, 0, 0, 0, 0);
    add(0, 1, 1, 0, 0, 9, 1, 1, 0, 0, 0);

    #2;
    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].en, vq[i].ud, vq[i].ld, vq[i].lval, vq[i].lim, vq[i].step);
      chk($sformatf("v%0d count", i), int'(w_cnt), int'(vq[i].ecnt));
      chk($sformatf("v%0d ovf", i),   int'(w_ovf), int'(vq[i].eovf));
      chk($sformatf("v%0d unf", i),   int'(w_unf), int'(vq[i].eunf));
      chk($sformatf("v%0d tc", i),    int'(w_tc),  int'(vq[i].etc));
    end

    // Saturate mode: up to 200 then hold, down to 0 then hold.
    drive(0, 0, 1, 1, 195, 200, 7); chk_sat("sat load195", 195, 0, 0, 0);
    drive(0, 1, 1, 0, 0, 200, 7);   chk_sat("sat up200", 200, 1, 0, 1);
    drive(0, 1, 1, 0, 0, 200, 7);   chk_sat("sat hold200", 200, 0, 0, 1);
    drive(0, 0, 0, 1, 3, 200, 7);   chk_sat("sat load3", 3, 0, 0, 0);
    drive(0, 1, 0, 0, 0, 200, 7);   chk_sat("sat dn0", 0, 0, 1, 1);
    drive(0, 1, 0, 0, 0, 200, 7);   chk_sat("sat hold0", 0, 0, 0, 1);

    // WIDTH=4 with LIMIT=15: 15+1 needs the extra carry bit.
    en = 1'b0; ld = 1'b0;
    f_ld = 1'b1; f_lval = 4'd14; f_ud = 1'b1; f_lim = 4'd15; f_step = 4'd1;
    @(posedge clk); #1;
    chk("w4 load14", int'(f_cnt), 14);
    f_ld = 1'b0; f_en = 1'b1;
    @(posedge clk); #1;
    chk("w4 count15", int'(f_cnt), 15);
    chk("w4 tc15", int'(f_tc), 1);
    @(posedge clk); #1;
    chk("w4 wrap count", int'(f_cnt), 0);
    chk("w4 wrap ovf", int'(f_ovf), 1);
    chk("w4 wrap tc", int'(f_tc), 0);
    @(posedge clk); #1;
    chk("w4 ovf drop", int'(f_ovf), 0);
    chk("w4 count1", int'(f_cnt), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
